// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT frame constants, complex sample type and bit-reversal helper
package fft_pkg;
  localparam int N = 16;
  localparam int LOG2N = 4;
  localparam int DW = 16;
  typedef logic [LOG2N-1:0] idx_t;
  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } cplx_t;
  function automatic idx_t bitrev(input idx_t a);
    idx_t r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_pingpong_ram.sv
// fft_pingpong_ram: two banks of N complex samples, one sync write port and one async read port
module fft_pingpong_ram
  import fft_pkg::*;
(
  input  logic  clk,
  input  logic  we_i,
  input  logic  wbank_i,
  input  idx_t  waddr_i,
  input  cplx_t wdata_i,
  input  logic  rbank_i,
  input  idx_t  raddr_i,
  output cplx_t rdata_o
);
  cplx_t mem_q [2*N];
  // store one sample into the selected bank; storage needs no reset
  always_ff @(posedge clk) if (we_i) mem_q[{wbank_i, waddr_i}] <= wdata_i;
  assign rdata_o = mem_q[{rbank_i, raddr_i}];
endmodule

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: ping-pong buffer turning bit-reversed FFT frames into natural order; FFT_REORDER_LAST_EN adds out_last
module fft_out_reorder
  import fft_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          in_push,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  output logic          in_stall,
  output logic          out_push,
  output logic [DW-1:0] out_real,
  output logic [DW-1:0] out_imag,
`ifdef FFT_REORDER_LAST_EN
  output logic          out_last,
`endif
  input  logic          out_stall
);
  idx_t       wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic       wsel_q, wsel_d, rsel_q, rsel_d;
  logic [1:0] full_q, full_d;
  logic       push_q, ld, wr, rd, wr_end, rd_end;
  cplx_t      rdata, out_q;
  assign in_stall = full_q[wsel_q];
  assign wr       = in_push && !in_stall;
  assign ld       = !push_q || !out_stall;
  assign rd       = ld && full_q[rsel_q];
  assign wr_end   = wr && wcnt_q == idx_t'(N-1);
  assign rd_end   = rd && rcnt_q == idx_t'(N-1);
  fft_pingpong_ram u_ram (
    .clk    (clk),
    .we_i   (wr),
    .wbank_i(wsel_q),
    .waddr_i(bitrev(wcnt_q)),
    .wdata_i(cplx_t'{re: in_real, im: in_imag}),
    .rbank_i(rsel_q),
    .raddr_i(rcnt_q),
    .rdata_o(rdata)
  );
  // counters wrap naturally at N; writer sets and reader clears full flags, always on different banks
  always_comb begin
    wcnt_d = wcnt_q + idx_t'(wr);
    rcnt_d = rcnt_q + idx_t'(rd);
    wsel_d = wsel_q ^ wr_end;
    rsel_d = rsel_q ^ rd_end;
    full_d = ({wsel_q, !wsel_q} & {2{wr_end}}) | (full_q & ~({rsel_q, !rsel_q} & {2{rd_end}}));
  end
  // bank bookkeeping state
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wcnt_q <= '0;
      rcnt_q <= '0;
      wsel_q <= 1'b0;
      rsel_q <= 1'b0;
      full_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      wsel_q <= wsel_d;
      rsel_q <= rsel_d;
      full_q <= full_d;
    end
  // output register: reloads whenever empty or drained, otherwise holds under stall
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      push_q <= 1'b0;
      out_q  <= '0;
    end else if (ld) begin
      push_q <= full_q[rsel_q];
      if (rd) out_q <= rdata;
    end
`ifdef FFT_REORDER_LAST_EN
  logic last_q;
  // frame-end marker travels with the sample in the output register
  always_ff @(posedge clk or posedge reset)
    if (reset) last_q <= 1'b0;
    else if (ld) last_q <= rd_end;
  assign out_last = last_q;
`endif
  assign out_push = push_q;
  assign out_real = out_q.re;
  assign out_imag = out_q.im;
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed self-checking bench for the bit-reversed to natural-order buffer
module tb_fft_out_reorder;
  import fft_pkg::*;
  logic          clk = 1'b0, reset = 1'b0, in_push = 1'b0, out_stall = 1'b0;
  logic [DW-1:0] in_real = '0, in_imag = '0, out_real, out_imag;
  logic          in_stall, out_push, lst;
  int            errs = 0, checks = 0, cyc = 0;
  logic [32:0]   outq[$];
  int            cycq[$];
  int            rev[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  always #5 clk = ~clk;
  fft_out_reorder dut (
    .clk      (clk),
    .reset    (reset),
    .in_push  (in_push),
    .in_real  (in_real),
    .in_imag  (in_imag),
    .in_stall (in_stall),
    .out_push (out_push),
    .out_real (out_real),
    .out_imag (out_imag),
`ifdef FFT_REORDER_LAST_EN
    .out_last (lst),
`endif
    .out_stall(out_stall)
  );
`ifndef FFT_REORDER_LAST_EN
  assign lst = 1'b0;
`endif
  // record every accepted output sample and the cycle it left
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && out_push && !out_stall) begin
      outq.push_back({lst, out_real, out_imag});
      cycq.push_back(cyc);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] pk(input int v);
    return {16'(v), 16'(-v)};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    outq.delete();
    cycq.delete();
  endtask
  task automatic do_reset;
    reset = 1'b1;
    #1;
    tick;
    reset = 1'b0;
    clr;
  endtask
  task automatic feed(input int base, input int n, output int st);
    int s, t;
    s = 0;
    t = 0;
    st = 0;
    in_push = 1'b1;
    while (s < n && t < 2000) begin
      in_real = 16'(base + s);
      in_imag = 16'(-(base + s));
      if (in_stall) st++;
      else s++;
      tick;
      t++;
    end
    in_push = 1'b0;
    if (s < n) chk("feed_timeout", s, n);
  endtask
  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (outq.size() < n && t < 500) begin
      tick;
      t++;
    end
    chk("out_count", outq.size(), n);
  endtask
  task automatic chk_frames(input int base, input int nf);
    for (int j = 0; j < nf * 16; j++)
      chk($sformatf("seq%0d", j), outq[j][31:0], pk(base + (j / 16) * 16 + rev[j % 16]));
  endtask
  initial begin
    int st, s, t;
    bit seen;
    reset = 1'b1;
    #1;
    chk("rst_push", out_push, 0);
    chk("rst_stall", in_stall, 0);
    chk("rst_data", {out_real, out_imag}, 0);
    tick;
    reset = 1'b0;
    clr;
    // single frame ordering and latency
    feed(0, 16, st);
    chk("order_stall", st, 0);
    chk("lat_not_yet", out_push, 0);
    tick;
    chk("lat_first_push", out_push, 1);
    chk("lat_first_data", {out_real, out_imag}, pk(0));
    wait_out(16);
    chk_frames(0, 1);
    // four back-to-back frames
    do_reset;
    feed(1000, 64, st);
    chk("stream_stall", st, 0);
    wait_out(64);
    chk("stream_gap", cycq[63] - cycq[0], 63);
    chk_frames(1000, 4);
    // both banks full under output stall
    do_reset;
    out_stall = 1'b1;
    in_push = 1'b1;
    s = 0;
    for (int i = 0; i < 33; i++) begin
      in_real = 16'(s);
      in_imag = 16'(-s);
      if (!in_stall) s++;
      tick;
    end
    chk("fs_accepted", s, 32);
    chk("fs_stall", in_stall, 1);
    out_stall = 1'b0;
    seen = 1'b0;
    t = 0;
    while (s < 40 && t < 200) begin
      in_real = 16'(s);
      in_imag = 16'(-s);
      if (!in_stall) begin
        if (!seen) begin
          chk("fs_release_data", {out_real, out_imag}, pk(15));
          chk("fs_release_cnt", outq.size(), 15);
          seen = 1'b1;
        end
        s++;
      end
      tick;
      t++;
    end
    in_push = 1'b0;
    chk("fs_total", s, 40);
    wait_out(32);
    chk_frames(0, 2);
    repeat (40) tick;
    chk("partial_held", outq.size(), 32);
    // output stall on index 6
    do_reset;
    feed(100, 16, st);
    t = 0;
    while (!(out_push && out_real == 16'd106) && t < 50) begin
      tick;
      t++;
    end
    chk("ostall_found", out_real, 106);
    out_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("ostall_push", out_push, 1);
      chk("ostall_data", {out_real, out_imag}, pk(106));
    end
    out_stall = 1'b0;
    wait_out(16);
    repeat (5) tick;
    chk("ostall_exact", outq.size(), 16);
    chk_frames(100, 1);
    // reset mid-frame while a prior frame streams out
    do_reset;
    feed(200, 16, st);
    feed(300, 9, st);
    chk("mid_push_before", out_push, 1);
    reset = 1'b1;
    #1;
    chk("mid_push_async", out_push, 0);
    chk("mid_stall_async", in_stall, 0);
    tick;
    reset = 1'b0;
    clr;
    feed(400, 16, st);
    wait_out(16);
    chk_frames(400, 1);
`ifdef FFT_REORDER_LAST_EN
    // frame-end marker, including a stall on the last sample
    do_reset;
    feed(500, 16, st);
    t = 0;
    while (!(out_push && lst) && t < 50) begin
      tick;
      t++;
    end
    chk("last_data", {out_real, out_imag}, pk(515));
    chk("last_cnt", outq.size(), 15);
    out_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("last_hold", {31'd0, lst}, 1);
    end
    out_stall = 1'b0;
    wait_out(16);
    for (int j = 0; j < 16; j++) chk($sformatf("last_bit%0d", j), {31'd0, outq[j][32]}, (j == 15) ? 1 : 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
